// File: rtl/data_framer_if.sv
// data_framer stream bundle: config/count input, payload input, framed output.
// master = framer side (drives framed output and readies); slave = environment.
interface data_framer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CFG_WIDTH  = 160
) ();
    logic [CFG_WIDTH-1:0]     s_axis_cfg;
    logic [DATA_WIDTH-11:0]   s_axis_cfg_num_pkts;
    logic                     s_axis_cfg_valid;
    logic                     s_axis_cfg_ready;

    logic [DATA_WIDTH-1:0]    s_axis_data;
    logic                     s_axis_data_valid;
    logic                     s_axis_data_ready;

    logic [DATA_WIDTH-1:0]    m_axis_framer_output;
    logic                     m_axis_framer_output_valid;
    logic                     m_axis_framer_output_last;
    logic                     m_axis_framer_output_ready;

    modport master (
        input  s_axis_cfg,
        input  s_axis_cfg_num_pkts,
        input  s_axis_cfg_valid,
        output s_axis_cfg_ready,
        input  s_axis_data,
        input  s_axis_data_valid,
        output s_axis_data_ready,
        output m_axis_framer_output,
        output m_axis_framer_output_valid,
        output m_axis_framer_output_last,
        input  m_axis_framer_output_ready
    );

    modport slave (
        output s_axis_cfg,
        output s_axis_cfg_num_pkts,
        output s_axis_cfg_valid,
        input  s_axis_cfg_ready,
        output s_axis_data,
        output s_axis_data_valid,
        input  s_axis_data_ready,
        input  m_axis_framer_output,
        input  m_axis_framer_output_valid,
        input  m_axis_framer_output_last,
        output m_axis_framer_output_ready
    );
endinterface

// File: rtl/data_framer.sv
// Transmit framer: header word, CFG_WORDS config words (LSB chunk first),
// then num_pkts data words, on one registered stream.
// Ports: clk, reset (sync, active-high), bus (data_framer_if.master):
//   s_axis_cfg/_num_pkts/_valid/_ready  config vector + data word count
//   s_axis_data/_valid/_ready           payload words
//   m_axis_framer_output/_valid/_last/_ready  framed output stream
module data_framer #(
    parameter int DATA_WIDTH = 64,
    parameter int CFG_WIDTH  = 160
) (
    input  logic          clk,
    input  logic          reset,
    data_framer_if.master bus
);
    localparam int CFG_WORDS = (CFG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CFG_PAD   = CFG_WORDS * DATA_WIDTH;
    localparam int CNT_W     = DATA_WIDTH - 10;
    localparam logic [3:0] LAST_CFG = 4'(CFG_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONFIG,
        DATA
    } state_t;

    state_t                  state_q, state_d;
    logic [CFG_PAD-1:0]      cfg_q, cfg_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic                    vld_q, vld_d;
    logic                    last_q, last_d;

    logic                    free;
    logic                    cfg_hs;
    logic                    data_hs;
    logic [DATA_WIDTH-1:0]   cfg_word;

    // The output register can take a new word when empty or draining.
    assign free = !vld_q || bus.m_axis_framer_output_ready;

    assign bus.s_axis_cfg_ready  = !reset && (state_q == IDLE) && free;
    assign bus.s_axis_data_ready = !reset && (state_q == DATA) && free;

    assign cfg_hs  = bus.s_axis_cfg_valid && bus.s_axis_cfg_ready;
    assign data_hs = bus.s_axis_data_valid && bus.s_axis_data_ready;

    assign bus.m_axis_framer_output       = out_q;
    assign bus.m_axis_framer_output_valid = vld_q;
    assign bus.m_axis_framer_output_last  = last_q;

    // Config word selected by cnt; padding above CFG_WIDTH is already zero.
    always_comb begin
        cfg_word = '0;
        for (int i = 0; i < CFG_WORDS; i++) begin
            if (cnt_q == 4'(i)) begin
                cfg_word = cfg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        vld_d   = vld_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    cfg_d                = '0;
                    cfg_d[CFG_WIDTH-1:0] = bus.s_axis_cfg;
                    rem_d                = bus.s_axis_cfg_num_pkts;
                    cnt_d                = '0;
                    out_d   = {bus.s_axis_cfg_num_pkts, 10'(CFG_WORDS)};
                    vld_d   = 1'b1;
                    last_d  = 1'b0;
                    state_d = CONFIG;
                end else if (free) begin
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                end
            end

            CONFIG: begin
                if (free) begin
                    out_d  = cfg_word;
                    vld_d  = 1'b1;
                    // A frame without data ends on its final config word.
                    last_d = (cnt_q == LAST_CFG) && (rem_q == '0);
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == LAST_CFG) begin
                        state_d = (rem_q != '0) ? DATA : IDLE;
                    end
                end
            end

            DATA: begin
                if (data_hs) begin
                    out_d  = bus.s_axis_data;
                    vld_d  = 1'b1;
                    last_d = (rem_q == CNT_W'(1));
                    if (rem_q != '0) begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end else if (free) begin
                    // Starved: let the pending word drain, never pad.
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_data_framer.sv
// Self-checking bench for data_framer: scoreboard + monitor,
// randomized payloads and backpressure against a frame-level model.
module tb_data_framer;
    localparam int DW = 64;
    localparam int CW = 160;
    localparam int NW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_framer_if #(.DATA_WIDTH(DW), .CFG_WIDTH(CW)) bus ();

    data_framer #(.DATA_WIDTH(DW), .CFG_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cyc = 0;

    logic [63:0] exp_w[$];
    bit          exp_l[$];
    logic [63:0] obs[$];
    int          obs_t[$];
    logic [63:0] dq[$];

    int last_cnt = 0;
    int idle_cnt = 0;
    int dready_cnt = 0;
    bit abort = 1'b0;
    bit rand_rdy = 1'b0;
    bit rdy_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Frame-level model: header then the config vector cut into 64-bit chunks.
    task automatic push_frame(input logic [CW-1:0] c, input logic [53:0] n);
        logic [63:0] nn;
        nn = 64'(n);
        exp_w.push_back((nn << 10) | 64'(NW));
        exp_l.push_back(1'b0);
        for (int i = 0; i < NW; i++) begin
            exp_w.push_back(64'(c >> (64 * i)));
            exp_l.push_back((n == 0) && (i == NW - 1));
        end
    endtask

    task automatic send_cfg(input logic [CW-1:0] c, input logic [53:0] n);
        bus.s_axis_cfg = c;
        bus.s_axis_cfg_num_pkts = n;
        bus.s_axis_cfg_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.s_axis_cfg_ready) begin
                push_frame(c, n);
                @(posedge clk);
                #1;
                hs_cyc = cyc;
                bus.s_axis_cfg_valid = 1'b0;
                return;
            end
        end
        bus.s_axis_cfg_valid = 1'b0;
        chk(1'b0, "cfg_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_data(input int gap);
        bit acc;
        for (int i = 0; i < dq.size(); i++) begin
            bus.s_axis_data = dq[i];
            bus.s_axis_data_valid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (abort) begin
                    bus.s_axis_data_valid = 1'b0;
                    return;
                end
                if (bus.s_axis_data_ready) begin
                    exp_w.push_back(dq[i]);
                    exp_l.push_back(i == dq.size() - 1);
                    acc = 1'b1;
                    break;
                end
            end
            if (!acc) begin
                bus.s_axis_data_valid = 1'b0;
                chk(1'b0, "data_timeout", 64'(i), 64'(dq.size()));
                return;
            end
            @(posedge clk);
            #1;
            bus.s_axis_data_valid = 1'b0;
            if (i != dq.size() - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    function automatic logic [CW-1:0] rand_cfg();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // Downstream ready driver.
    initial begin
        bus.m_axis_framer_output_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.m_axis_framer_output_ready =
                rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stalls.
    initial begin
        bit          pend;
        logic [63:0] sd;
        bit          sl;
        pend = 1'b0;
        sd = '0;
        sl = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk(bus.m_axis_framer_output_valid, "stall_valid",
                        64'(bus.m_axis_framer_output_valid), 64'd1);
                    chk(bus.m_axis_framer_output == sd, "stall_data",
                        bus.m_axis_framer_output, sd);
                    chk(bus.m_axis_framer_output_last == sl, "stall_last",
                        64'(bus.m_axis_framer_output_last), 64'(sl));
                end
                pend = bus.m_axis_framer_output_valid &&
                       !bus.m_axis_framer_output_ready;
                sd = bus.m_axis_framer_output;
                sl = bus.m_axis_framer_output_last;
                if (bus.m_axis_framer_output_valid &&
                    bus.m_axis_framer_output_ready) begin
                    obs.push_back(bus.m_axis_framer_output);
                    obs_t.push_back(cyc);
                    if (bus.m_axis_framer_output_last) last_cnt++;
                    if (exp_w.size() == 0) begin
                        chk(1'b0, "unexpected_beat",
                            bus.m_axis_framer_output, 64'd0);
                    end else begin
                        logic [63:0] ew;
                        bit el;
                        ew = exp_w.pop_front();
                        el = exp_l.pop_front();
                        chk(bus.m_axis_framer_output == ew, "beat_data",
                            bus.m_axis_framer_output, ew);
                        chk(bus.m_axis_framer_output_last == el, "beat_last",
                            64'(bus.m_axis_framer_output_last), 64'(el));
                    end
                end
                if (!bus.m_axis_framer_output_valid) idle_cnt++;
                if (bus.s_axis_data_ready) dready_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a_exp [6];
        logic [CW-1:0] c;
        int ob, lb, db, ib;
        int np [3];

        a_exp[0] = 64'h0000_0000_0000_0803;
        a_exp[1] = 64'h1111_2222_3333_4444;
        a_exp[2] = 64'hCCCC_DDDD_EEEE_FFFF;
        a_exp[3] = 64'h0000_0000_AAAA_BBBB;
        a_exp[4] = 64'h10;
        a_exp[5] = 64'h20;
        np[0] = 1;
        np[1] = 5;
        np[2] = 0;

        bus.s_axis_cfg = '0;
        bus.s_axis_cfg_num_pkts = '0;
        bus.s_axis_cfg_valid = 1'b1;
        bus.s_axis_data = '0;
        bus.s_axis_data_valid = 1'b1;

        // Reset state, with valids high to prove readies stay low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!bus.m_axis_framer_output_valid, "rst_valid",
            64'(bus.m_axis_framer_output_valid), 64'd0);
        chk(bus.m_axis_framer_output == 64'd0, "rst_data",
            bus.m_axis_framer_output, 64'd0);
        chk(!bus.m_axis_framer_output_last, "rst_last",
            64'(bus.m_axis_framer_output_last), 64'd0);
        chk(!bus.s_axis_cfg_ready, "rst_cfg_ready",
            64'(bus.s_axis_cfg_ready), 64'd0);
        chk(!bus.s_axis_data_ready, "rst_data_ready",
            64'(bus.s_axis_data_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.s_axis_cfg_valid = 1'b0;
        bus.s_axis_data_valid = 1'b0;
        @(negedge clk);
        chk(bus.s_axis_cfg_ready, "idle_cfg_ready",
            64'(bus.s_axis_cfg_ready), 64'd1);
        chk(!bus.s_axis_data_ready, "idle_data_ready",
            64'(bus.s_axis_data_ready), 64'd0);
        @(posedge clk);
        #1;

        // Directed frame with the fixed reference words.
        ob = obs.size();
        dq.delete();
        dq.push_back(64'h10);
        dq.push_back(64'h20);
        c = 160'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444;
        fork
            send_cfg(c, 54'd2);
            send_data(0);
        join
        repeat (6) @(posedge clk);
        #1;
        chk(obs.size() - ob == 6, "dir_len", 64'(obs.size() - ob), 64'd6);
        if (obs.size() - ob == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk(obs[ob+i] == a_exp[i], "dir_word", obs[ob+i], a_exp[i]);
            end
            chk(obs_t[ob] == hs_cyc, "dir_header_latency",
                64'(obs_t[ob]), 64'(hs_cyc));
            chk(obs_t[ob+5] - obs_t[ob] == 5, "dir_no_bubbles",
                64'(obs_t[ob+5] - obs_t[ob]), 64'd5);
        end

        // Frame without data.
        ob = obs.size();
        lb = last_cnt;
        db = dready_cnt;
        send_cfg(rand_cfg(), 54'd0);
        repeat (8) @(posedge clk);
        #1;
        chk(obs.size() - ob == 4, "zero_len", 64'(obs.size() - ob), 64'd4);
        chk(last_cnt - lb == 1, "zero_last", 64'(last_cnt - lb), 64'd1);
        chk(dready_cnt == db, "zero_dready", 64'(dready_cnt - db), 64'd0);
        chk(exp_w.size() == 0, "zero_drain", 64'(exp_w.size()), 64'd0);

        // Back-to-back frames under random backpressure.
        ob = obs.size();
        lb = last_cnt;
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            dq.delete();
            for (int i = 0; i < np[f]; i++) dq.push_back(rand_word());
            fork
                send_cfg(rand_cfg(), 54'(np[f]));
                send_data(0);
            join
        end
        repeat (40) @(posedge clk);
        rand_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(obs.size() - ob == 18, "b2b_len", 64'(obs.size() - ob), 64'd18);
        chk(last_cnt - lb == 3, "b2b_last", 64'(last_cnt - lb), 64'd3);
        chk(exp_w.size() == 0, "b2b_drain", 64'(exp_w.size()), 64'd0);

        // Gapped payload: one valid cycle in three.
        ob = obs.size();
        dq.delete();
        for (int i = 0; i < 4; i++) dq.push_back(rand_word());
        ib = 0;
        fork
            begin
                send_cfg(rand_cfg(), 54'd4);
                ib = idle_cnt;
            end
            send_data(2);
        join
        chk(idle_cnt - ib == 6, "gap_idle", 64'(idle_cnt - ib), 64'd6);
        repeat (4) @(posedge clk);
        #1;
        chk(obs.size() - ob == 8, "gap_len", 64'(obs.size() - ob), 64'd8);
        chk(exp_w.size() == 0, "gap_drain", 64'(exp_w.size()), 64'd0);

        // Reset while the second data word is stalled.
        dq.delete();
        dq.push_back(64'hD1);
        dq.push_back(64'hD2);
        dq.push_back(64'hD3);
        dq.push_back(64'hD4);
        fork
            send_cfg(rand_cfg(), 54'd4);
            send_data(0);
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 300; k++) begin
                    @(posedge clk);
                    #1;
                    if (bus.m_axis_framer_output_valid &&
                        bus.m_axis_framer_output == 64'hD2) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk(seen, "rst_reach_d2", 64'(seen), 64'd1);
                rdy_force = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                abort = 1'b1;
                reset = 1'b1;
                bus.s_axis_cfg_valid = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk(!bus.m_axis_framer_output_valid, "midrst_valid",
                    64'(bus.m_axis_framer_output_valid), 64'd0);
                chk(!bus.m_axis_framer_output_last, "midrst_last",
                    64'(bus.m_axis_framer_output_last), 64'd0);
                chk(!bus.s_axis_cfg_ready, "midrst_cfg_ready",
                    64'(bus.s_axis_cfg_ready), 64'd0);
                chk(!bus.s_axis_data_ready, "midrst_data_ready",
                    64'(bus.s_axis_data_ready), 64'd0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                bus.s_axis_cfg_valid = 1'b0;
            end
        join
        exp_w.delete();
        exp_l.delete();
        abort = 1'b0;
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        ob = obs.size();
        dq.delete();
        dq.push_back(rand_word());
        fork
            send_cfg(rand_cfg(), 54'd1);
            send_data(0);
        join
        repeat (6) @(posedge clk);
        #1;
        chk(obs.size() - ob == 5, "post_len", 64'(obs.size() - ob), 64'd5);
        if (obs.size() > ob) begin
            chk(obs[ob] == ((64'd1 << 10) | 64'(NW)), "post_header",
                obs[ob], (64'd1 << 10) | 64'(NW));
        end
        chk(exp_w.size() == 0, "post_drain", 64'(exp_w.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
